// File: rtl/iob_cache_wtb_ctrl.sv
// rtl/iob_cache_wtb_ctrl.sv - write-through buffer feeding the cache AXI write channel
// Head entry is held stable from acceptance until the completion pulse retires it.
module iob_cache_wtb_ctrl #(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 32,
    parameter int DEPTH_W  = 2,
    parameter int ACACHE_W = 4,
    localparam int FE_NBYTES   = DATA_W / 8,
    localparam int FE_NBYTES_W = $clog2(FE_NBYTES),
    localparam int WADDR_W     = ADDR_W - FE_NBYTES_W
) (
    input  logic                clk_i,
    input  logic                reset_n_i,

    input  logic                fe_valid_i,
    input  logic [WADDR_W-1:0]  fe_addr_i,
    input  logic [DATA_W-1:0]   fe_wdata_i,
    input  logic [FE_NBYTES-1:0] fe_wstrb_i,
    input  logic [ACACHE_W-1:0] fe_acache_i,
    output logic                fe_ready_o,

    output logic                wch_valid_o,
    output logic [WADDR_W-1:0]  wch_addr_o,
    output logic [DATA_W-1:0]   wch_wdata_o,
    output logic [FE_NBYTES-1:0] wch_wstrb_o,
    output logic [ACACHE_W-1:0] wch_acache_o,
    input  logic                wch_ready_i,

    output logic                empty_o,
    output logic                full_o,
    output logic [DEPTH_W:0]    level_o
);

    localparam int DEPTH = 2 ** DEPTH_W;
    localparam logic [DEPTH_W:0] DEPTH_CNT = (DEPTH_W + 1)'(DEPTH);
    localparam logic [DEPTH_W:0] CNT_ONE   = (DEPTH_W + 1)'(1);
    localparam logic [DEPTH_W:0] CNT_TWO   = (DEPTH_W + 1)'(2);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t state, state_nxt;

    logic [WADDR_W-1:0]   mem_addr   [DEPTH];
    logic [DATA_W-1:0]    mem_wdata  [DEPTH];
    logic [FE_NBYTES-1:0] mem_wstrb  [DEPTH];
    logic [ACACHE_W-1:0]  mem_acache [DEPTH];

    logic [DEPTH_W-1:0] rd_ptr, wr_ptr;
    logic [DEPTH_W:0]   count;
    logic               push, pop;

    assign full_o     = (count == DEPTH_CNT);
    assign fe_ready_o = ~full_o;
    assign push       = fe_valid_i & ~full_o;
    assign level_o    = count;
    assign empty_o    = (count == '0) && (state == ST_IDLE);

    assign wch_addr_o   = mem_addr[rd_ptr];
    assign wch_wdata_o  = mem_wdata[rd_ptr];
    assign wch_wstrb_o  = mem_wstrb[rd_ptr];
    assign wch_acache_o = mem_acache[rd_ptr];

    // In ACTIVE the head is in flight, so only a second entry may be offered;
    // wch_ready_i is then the completion pulse rather than an acceptance.
    always_comb begin
        state_nxt   = state;
        wch_valid_o = 1'b0;
        pop         = 1'b0;
        case (state)
            ST_IDLE: begin
                wch_valid_o = (count != '0);
                if (wch_valid_o && wch_ready_i) begin
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                wch_valid_o = (count >= CNT_TWO);
                if (wch_ready_i) begin
                    pop       = 1'b1;
                    state_nxt = (count >= CNT_TWO) ? ST_ACTIVE : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state  <= ST_IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Storage is deliberately left unreset; outputs are don't-care while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_addr[wr_ptr]   <= fe_addr_i;
            mem_wdata[wr_ptr]  <= fe_wdata_i;
            mem_wstrb[wr_ptr]  <= fe_wstrb_i;
            mem_acache[wr_ptr] <= fe_acache_i;
        end
    end

endmodule

// File: tb/tb_iob_cache_wtb_ctrl.sv
// tb/tb_iob_cache_wtb_ctrl.sv - scoreboard bench for iob_cache_wtb_ctrl
module tb_iob_cache_wtb_ctrl;

    localparam int ADDR_W   = 24;
    localparam int DATA_W   = 32;
    localparam int DEPTH_W  = 2;
    localparam int ACACHE_W = 4;
    localparam int NB       = DATA_W / 8;
    localparam int WA       = ADDR_W - 2;
    localparam int DEPTH    = 2 ** DEPTH_W;

    typedef struct packed {
        logic [WA-1:0]       addr;
        logic [DATA_W-1:0]   data;
        logic [NB-1:0]       strb;
        logic [ACACHE_W-1:0] acache;
    } entry_t;

    logic                clk_i = 1'b0;
    logic                reset_n_i = 1'b0;
    logic                fe_valid_i = 1'b0;
    logic [WA-1:0]       fe_addr_i = '0;
    logic [DATA_W-1:0]   fe_wdata_i = '0;
    logic [NB-1:0]       fe_wstrb_i = '0;
    logic [ACACHE_W-1:0] fe_acache_i = '0;
    logic                fe_ready_o;
    logic                wch_valid_o;
    logic [WA-1:0]       wch_addr_o;
    logic [DATA_W-1:0]   wch_wdata_o;
    logic [NB-1:0]       wch_wstrb_o;
    logic [ACACHE_W-1:0] wch_acache_o;
    logic                wch_ready_i = 1'b0;
    logic                empty_o;
    logic                full_o;
    logic [DEPTH_W:0]    level_o;

    iob_cache_wtb_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_W(DEPTH_W), .ACACHE_W(ACACHE_W)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .fe_valid_i(fe_valid_i), .fe_addr_i(fe_addr_i), .fe_wdata_i(fe_wdata_i),
        .fe_wstrb_i(fe_wstrb_i), .fe_acache_i(fe_acache_i), .fe_ready_o(fe_ready_o),
        .wch_valid_o(wch_valid_o), .wch_addr_o(wch_addr_o), .wch_wdata_o(wch_wdata_o),
        .wch_wstrb_o(wch_wstrb_o), .wch_acache_o(wch_acache_o), .wch_ready_i(wch_ready_i),
        .empty_o(empty_o), .full_o(full_o), .level_o(level_o)
    );

    always #5 clk_i = ~clk_i;

    int     checks = 0;
    int     failures = 0;
    entry_t exp_q[$];
    bit     model_active = 1'b0;

    function automatic entry_t rand_entry();
        entry_t e;
        e.addr   = WA'($urandom);
        e.data   = $urandom;
        e.strb   = NB'($urandom);
        e.acache = ACACHE_W'($urandom);
        return e;
    endfunction

    function automatic entry_t head_out();
        return {wch_addr_o, wch_wdata_o, wch_wstrb_o, wch_acache_o};
    endfunction

    // Drives one cycle from a negedge; pushes accepted writes into the scoreboard
    // and pops/compares the head whenever the channel accepts or completes it.
    task automatic step(input bit v, input entry_t e, input bit rdy);
        int  sz;
        bit  exp_valid;
        sz = exp_q.size();
        exp_valid = model_active ? (sz >= 2) : (sz != 0);
        fe_valid_i  = v;
        {fe_addr_i, fe_wdata_i, fe_wstrb_i, fe_acache_i} = e;
        wch_ready_i = rdy;
        checks++;
        if (wch_valid_o !== exp_valid) begin
            failures++;
            $display("FAIL wch_valid: got %b expected %b", wch_valid_o, exp_valid);
        end
        checks++;
        if (fe_ready_o !== (sz < DEPTH)) begin
            failures++;
            $display("FAIL fe_ready: got %b expected %b", fe_ready_o, (sz < DEPTH));
        end
        if (rdy && (model_active || sz != 0)) begin
            checks++;
            if (head_out() !== exp_q[0]) begin
                failures++;
                $display("FAIL head_%s: got %h expected %h",
                         model_active ? "complete" : "accept", head_out(), exp_q[0]);
            end
            if (model_active) begin
                void'(exp_q.pop_front());
                model_active = (sz >= 2);
            end else begin
                model_active = 1'b1;
            end
        end
        if (v && sz < DEPTH) exp_q.push_back(e);
        @(posedge clk_i);
        @(negedge clk_i);
        fe_valid_i  = 1'b0;
        wch_ready_i = 1'b0;
        checks++;
        if (level_o !== (DEPTH_W+1)'(exp_q.size())) begin
            failures++;
            $display("FAIL level: got %0d expected %0d", level_o, exp_q.size());
        end
        checks++;
        if (empty_o !== (exp_q.size() == 0 && !model_active)) begin
            failures++;
            $display("FAIL empty: got %b expected %b", empty_o, (exp_q.size() == 0 && !model_active));
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || model_active) && n < 40) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || model_active) begin
            failures++;
            $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;
        exp_q.delete();
        model_active = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({wch_valid_o, fe_ready_o, full_o, empty_o, level_o} !== {1'b0, 1'b1, 1'b0, 1'b1, 3'd0}) begin
            failures++;
            $display("FAIL reset_state: got v%b r%b f%b e%b l%0d expected v0 r1 f0 e1 l0",
                     wch_valid_o, fe_ready_o, full_o, empty_o, level_o);
        end
    endtask

    task automatic test_single();
        entry_t e;
        e.addr = 22'h012345; e.data = 32'hDEADBEEF; e.strb = 4'hF; e.acache = 4'h3;
        step(1'b1, e, 1'b0);
        checks++;
        if (wch_valid_o !== 1'b1 || head_out() !== e) begin
            failures++;
            $display("FAIL single_latency: got v%b %h expected v1 %h", wch_valid_o, head_out(), e);
        end
        step(1'b0, '0, 1'b1);
        checks++;
        if (wch_valid_o !== 1'b0 || empty_o !== 1'b0) begin
            failures++;
            $display("FAIL single_active: got v%b e%b expected v0 e0", wch_valid_o, empty_o);
        end
        repeat (4) step(1'b0, '0, 1'b0);
        checks++;
        if (head_out() !== e) begin
            failures++;
            $display("FAIL single_stable: got %h expected %h", head_out(), e);
        end
        step(1'b0, '0, 1'b1);
        checks++;
        if (empty_o !== 1'b1) begin
            failures++;
            $display("FAIL single_empty: got %b expected 1", empty_o);
        end
    endtask

    task automatic test_full();
        repeat (DEPTH) step(1'b1, rand_entry(), 1'b0);
        checks++;
        if (full_o !== 1'b1 || level_o !== 3'd4 || fe_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL full_state: got f%b l%0d r%b expected f1 l4 r0", full_o, level_o, fe_ready_o);
        end
        step(1'b1, rand_entry(), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        checks++;
        if (fe_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL full_release: got %b expected 1", fe_ready_o);
        end
        drain();
    endtask

    task automatic test_chain();
        repeat (3) step(1'b1, rand_entry(), 1'b0);
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1);
            if (i < 2) begin
                checks++;
                if (empty_o !== 1'b0 || wch_valid_o !== 1'b1 && exp_q.size() >= 2) begin
                    failures++;
                    $display("FAIL chain_hold: got e%b v%b expected e0", empty_o, wch_valid_o);
                end
                step(1'b0, '0, 1'b0);
            end
        end
        checks++;
        if (empty_o !== 1'b1) begin
            failures++;
            $display("FAIL chain_end: got %b expected 1", empty_o);
        end
    endtask

    task automatic test_back_to_back();
        repeat (2) step(1'b1, rand_entry(), 1'b0);
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, rand_entry(), 1'b1);
            checks++;
            if (level_o !== 3'd2) begin
                failures++;
                $display("FAIL b2b_level: got %0d expected 2", level_o);
            end
        end
        drain();
    endtask

    task automatic test_retry();
        entry_t h;
        repeat (2) step(1'b1, rand_entry(), 1'b0);
        h = exp_q[0];
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0, 1'b0);
            checks++;
            if (head_out() !== h || level_o !== 3'd2) begin
                failures++;
                $display("FAIL retry_hold: got %h l%0d expected %h l2", head_out(), level_o, h);
            end
        end
        drain();
    endtask

    task automatic test_async_reset();
        repeat (3) step(1'b1, rand_entry(), 1'b0);
        step(1'b0, '0, 1'b1);
        #2 reset_n_i = 1'b0;
        #1;
        checks++;
        if ({wch_valid_o, empty_o, level_o, fe_ready_o} !== {1'b0, 1'b1, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL async_reset: got v%b e%b l%0d r%b expected v0 e1 l0 r1",
                     wch_valid_o, empty_o, level_o, fe_ready_o);
        end
        exp_q.delete();
        model_active = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        step(1'b0, '0, 1'b0);
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_single();
        test_full();
        test_chain();
        test_back_to_back();
        test_retry();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iob_cache_wtb_ctrl.md
Name: iob_cache_wtb_ctrl

Overview:
- Write-through buffer controller sitting directly upstream of the cache's AXI write channel.
- Queues front-end write-through words (address, data, strobe, AXI cache attributes) in a register FIFO.
- Presents the head entry to the write channel and holds it stable across the write channel's two-phase handshake: accept in its idle state, then complete on a good B response.
- Retires the head only on completion, and reports buffer-empty / all-writes-retired status to the cache control.

Parameters:
- ADDR_W, 24, front-end byte address width.
- DATA_W, 32, front-end word width; FE_NBYTES=DATA_W/8, FE_NBYTES_W=$clog2(FE_NBYTES).
- DEPTH_W, 2, log2 of FIFO depth (DEPTH=2**DEPTH_W entries); legal range 1..5.
- ACACHE_W, 4, AXI cache attribute width carried per entry.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- fe_valid_i  in  1  push request from cache front-end.
- fe_addr_i  in  ADDR_W-FE_NBYTES_W  word address (ADDR_W-1:FE_NBYTES_W).
- fe_wdata_i  in  DATA_W  write data.
- fe_wstrb_i  in  FE_NBYTES  byte strobes.
- fe_acache_i  in  ACACHE_W  AXI awcache for this write.
- fe_ready_o  out  1  push accepted when fe_valid_i & fe_ready_o.
- wch_valid_o  out  1  head entry offered to the write channel.
- wch_addr_o  out  ADDR_W-FE_NBYTES_W  head address.
- wch_wdata_o  out  DATA_W  head data.
- wch_wstrb_o  out  FE_NBYTES  head strobes.
- wch_acache_o  out  ACACHE_W  head cache attributes.
- wch_ready_i  in  1  write channel ready; meaning depends on state, see below.
- empty_o  out  1  FIFO empty and no write outstanding.
- full_o  out  1  FIFO holds DEPTH entries.
- level_o  out  DEPTH_W+1  current entry count.

Behaviour:
- Storage:
  - DEPTH-entry register array with rd_ptr and wr_ptr (DEPTH_W bits, natural wrap) and count (DEPTH_W+1 bits).
  - wch_* data outputs are driven combinationally from mem[rd_ptr].
- Push:
  - fe_ready_o = ~full_o, purely combinational; no bypass.
  - A push while full is impossible by handshake; when full, fe_valid_i is ignored.
  - On push, the entry is written at wr_ptr and wr_ptr increments.
- State machine (2 states, reset to ST_IDLE):
  - ST_IDLE: wch_valid_o = (count!=0).
    - If wch_valid_o & wch_ready_i, go to ST_ACTIVE. This is acceptance; no pop.
  - ST_ACTIVE: head write in flight; the head entry must stay stable.
    - wch_valid_o = (count>=2), so the write channel can chain directly from its verify state.
    - wch_ready_i high is the completion pulse: pop the head (rd_ptr+1, count-1).
    - On completion, stay in ST_ACTIVE if count>=2 (next entry already accepted), else go to ST_IDLE.
    - wch_ready_i low: hold state. Error responses produce no pulse, so the head is retried unchanged.
- count update:
  - push only: +1.
  - pop only: -1.
  - push & pop in the same cycle: unchanged; both pointers advance.
- Push into an empty FIFO in ST_IDLE: wch_valid_o rises the cycle after the push (registered storage); latency from fe handshake to wch_valid_o is 1 cycle.
- Push during ST_ACTIVE with count==1: count becomes 2, so wch_valid_o rises next cycle, in time for a later completion pulse to chain.
- Status outputs:
  - full_o = (count==DEPTH).
  - empty_o = (count==0) & (state==ST_IDLE).
  - level_o = count.
- Reset (asynchronous assert, synchronous release):
  - state=ST_IDLE, pointers=0, count=0.
  - Resulting outputs: wch_valid_o=0, fe_ready_o=1, full_o=0, empty_o=1, level_o=0.
  - Storage contents are not reset; wch_* data outputs are don't-care while wch_valid_o=0.
  - Reset mid-transfer discards all entries, including the in-flight one.

Test Plan:
- Reset, then a single push (addr 0x12345, data 0xDEADBEEF, strb 0xF, acache 0x3) -> wch_valid_o=1 next cycle with the same fields.
  - ready pulse -> ST_ACTIVE with wch_valid_o=0, fields stable.
  - Second pulse 5 cycles later -> pop; empty_o=1 the following cycle.
- Push 4 entries with DEPTH_W=2 -> full_o=1, level_o=4, fe_ready_o=0; a 5th fe_valid_i is ignored.
  - One completion -> fe_ready_o=1 next cycle.
- Chained drain of 3 entries -> on each completion pulse wch_valid_o=1 while count>=2; the state never returns to ST_IDLE until the last pulse.
  - Entries emerge in FIFO order with no data change inside each transaction.
- Push and completion in the same cycle at count==2 -> count stays 2 and both pointers advance.
  - Pointer wrap verified over 10 entries; output order correct.
- Error retry: accept, then hold wch_ready_i low for 20 cycles (modelling a retried bresp!=0) -> the head stays unchanged and level_o stays constant until the pulse.
- Assert reset_n_i asynchronously mid-ACTIVE with 3 entries -> immediately wch_valid_o=0, empty_o=1, level_o=0, fe_ready_o=1.
